// File: rtl/dft.sv
// Constant-Q sliding DFT front end: one sample per strobe, all log-spaced bins swept through a
// lookup / multiply / accumulate pipeline, with a registered |re|+|im| magnitude per bin.
//
// state | meaning
// IDLE  | waiting for readSample; captures the sample and starts a sweep
// SWEEP | issuing one bin per clock (bin_cnt = 0..BINCOUNT-1)
// DRAIN | last bin issued, pipeline emptying; strobes still ignored
module dft #(
    parameter int BPO     = 24,
    parameter int OC      = 5,
    parameter int N       = 16,
    parameter int TOPSIZE = 2048
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] inputSample,
    input  logic                readSample,
    output logic [35:0]         outBins [BPO*OC]
);
    localparam int BINCOUNT = BPO * OC;
    localparam int BW       = $clog2(BINCOUNT);
    localparam int TOPLOG   = $clog2(TOPSIZE);
    localparam int AW       = 34;
    localparam int PW       = N + 1;
    localparam logic signed [AW+1:0] SAT_POS = 36'sh1_FFFF_FFFF;
    localparam logic signed [AW+1:0] SAT_NEG = -SAT_POS;

    function automatic int sin_entry(input int i);
        return $rtoi(32767.0 * $sin(6.283185307179586 * real'(i) / 1024.0) + 0.5);
    endfunction

    function automatic int inc_entry(input int b);
        return $rtoi(16384.0 * (2.0 ** (real'(b - (BINCOUNT - 1)) / real'(BPO))) + 0.5);
    endfunction

    // Positive quarter of a sine wave; the other quadrants come from symmetry.
    logic [14:0] sin_rom [256];
    logic [15:0] inc_rom [BINCOUNT];

    for (genvar g = 0; g < 256; g++) begin : g_sin
        localparam int V = sin_entry(g);
        assign sin_rom[g] = V[14:0];
    end

    for (genvar g = 0; g < BINCOUNT; g++) begin : g_inc
        localparam int V = inc_entry(g);
        assign inc_rom[g] = V[15:0];
    end

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t              state, state_nx;
    logic [BW-1:0]       bin_cnt, bin_cnt_nx;
    logic [1:0]          drain_cnt, drain_cnt_nx;
    logic signed [N-1:0] x_reg, x_nx;
    logic                issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bin_cnt   <= '0;
            drain_cnt <= '0;
            x_reg     <= '0;
        end else begin
            state     <= state_nx;
            bin_cnt   <= bin_cnt_nx;
            drain_cnt <= drain_cnt_nx;
            x_reg     <= x_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bin_cnt_nx   = bin_cnt;
        drain_cnt_nx = drain_cnt;
        x_nx         = x_reg;
        issue        = 1'b0;
        case (state)
            IDLE: begin
                if (readSample) begin
                    state_nx   = SWEEP;
                    x_nx       = inputSample;
                    bin_cnt_nx = '0;
                end
            end
            SWEEP: begin
                issue = 1'b1;
                if (bin_cnt == BW'(BINCOUNT - 1)) begin
                    state_nx     = DRAIN;
                    drain_cnt_nx = 2'd2;
                end else begin
                    bin_cnt_nx = bin_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd0) state_nx = IDLE;
                else drain_cnt_nx = drain_cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    logic [15:0]        phase [BINCOUNT];
    logic [15:0]        ph_rd;
    logic [7:0]         q_idx, rev_idx;
    logic signed [15:0] fwd, rev, cos_v, sin_v;

    always_comb begin
        ph_rd   = phase[bin_cnt];
        q_idx   = ph_rd[13:6];
        rev_idx = ~q_idx + 8'd1;
        fwd     = {1'b0, sin_rom[q_idx]};
        rev     = (q_idx == 8'd0) ? 16'sd32767 : {1'b0, sin_rom[rev_idx]};
        cos_v   = rev;
        sin_v   = fwd;
        case (ph_rd[15:14])
            2'd0: begin sin_v = fwd;  cos_v = rev;  end
            2'd1: begin sin_v = rev;  cos_v = -fwd; end
            2'd2: begin sin_v = -fwd; cos_v = -rev; end
            2'd3: begin sin_v = -rev; cos_v = fwd;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BINCOUNT; i++) phase[i] <= '0;
        end else if (issue) begin
            phase[bin_cnt] <= ph_rd + inc_rom[bin_cnt];
        end
    end

    logic               s1_valid, s2_valid;
    logic [BW-1:0]      s1_bin, s2_bin;
    logic signed [15:0] s1_cos, s1_sin;
    logic signed [PW-1:0] s2_pre, s2_pim;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_bin   <= '0;
            s1_cos   <= '0;
            s1_sin   <= '0;
            s2_valid <= 1'b0;
            s2_bin   <= '0;
            s2_pre   <= '0;
            s2_pim   <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_bin <= bin_cnt;
                s1_cos <= cos_v;
                s1_sin <= sin_v;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_bin <= s1_bin;
                // Q1.15 product scaled back with floor rounding.
                s2_pre <= PW'(((N+16)'(x_reg) * (N+16)'(s1_cos)) >>> 15);
                s2_pim <= PW'(((N+16)'(x_reg) * (N+16)'(s1_sin)) >>> 15);
            end
        end
    end

    function automatic logic signed [AW-1:0] acc_step(input logic signed [AW-1:0] acc,
                                                      input logic [4:0]           sh,
                                                      input logic signed [PW-1:0] p);
        logic signed [AW-1:0] leak;
        logic signed [AW+1:0] sum;
        leak = acc >>> sh;
        sum  = {{2{acc[AW-1]}}, acc} - {{2{leak[AW-1]}}, leak} + {{(AW+2-PW){p[PW-1]}}, p};
        if (sum > SAT_POS) return SAT_POS[AW-1:0];
        if (sum < SAT_NEG) return SAT_NEG[AW-1:0];
        return sum[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] mag(input logic signed [AW-1:0] v);
        return v[AW-1] ? -v : v;
    endfunction

    logic signed [AW-1:0] acc_re [BINCOUNT];
    logic signed [AW-1:0] acc_im [BINCOUNT];
    logic signed [AW-1:0] re_nx, im_nx;
    logic [AW:0]          mag_nx;
    logic [4:0]           shamt;
    int                   oct;

    // Lower octaves integrate over longer windows, so their leak shift grows by one per octave.
    always_comb begin
        oct    = int'(s2_bin) / BPO;
        shamt  = 5'(TOPLOG + OC - 1 - oct);
        re_nx  = acc_step(acc_re[s2_bin], shamt, s2_pre);
        im_nx  = acc_step(acc_im[s2_bin], shamt, s2_pim);
        mag_nx = {1'b0, mag(re_nx)} + {1'b0, mag(im_nx)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BINCOUNT; i++) begin
                acc_re[i]  <= '0;
                acc_im[i]  <= '0;
                outBins[i] <= '0;
            end
        end else if (s2_valid) begin
            acc_re[s2_bin]  <= re_nx;
            acc_im[s2_bin]  <= im_nx;
            outBins[s2_bin] <= {1'b0, mag_nx};
        end
    end

endmodule

// File: tb/tb_dft.sv
// Bench for dft: a behavioural sliding-DFT model feeds a per-bin scoreboard, plus a vector
// table for bin 119 and hand sequences for latency, dropped strobes and mid-sweep reset.
module tb_dft;
    localparam int     BPO      = 24;
    localparam int     OC       = 5;
    localparam int     BINCOUNT = BPO * OC;
    localparam real    PI       = 3.14159265358979323846;
    localparam longint SATV     = 64'sd8589934591;

    logic               clk, rst, readSample;
    logic signed [15:0] inputSample;
    logic [35:0]        outBins [BINCOUNT];

    dft #(.BPO(BPO), .OC(OC), .N(16), .TOPSIZE(2048)) dut (
        .clk(clk), .rst(rst), .inputSample(inputSample),
        .readSample(readSample), .outBins(outBins)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int bin; int due; logic [35:0] val; } sb_t;
    typedef struct { int sample; logic [35:0] exp119; } vec_t;

    sb_t         sb [$];
    vec_t        vecs [6];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          last_acc = -1000;
    int          strobe_cyc = 0;
    longint      m_re [BINCOUNT];
    longint      m_im [BINCOUNT];
    int          m_ph [BINCOUNT];
    int          m_inc [BINCOUNT];
    logic [35:0] m_out [BINCOUNT];

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        sb_t e;
        if (rst) begin
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                check($sformatf("sb_bin%0d_cyc%0d", e.bin, e.due), outBins[e.bin], e.val);
            end
        end
    end

    function automatic longint rnd(input real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
    endfunction

    function automatic longint sat(input longint v);
        if (v > SATV) return SATV;
        if (v < -SATV) return -SATV;
        return v;
    endfunction

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < BINCOUNT; b++) begin
            m_re[b] = 0; m_im[b] = 0; m_ph[b] = 0; m_out[b] = '0;
        end
        sb.delete();
        last_acc = -1000;
    endtask

    task automatic model_step(input int smp, input int sc);
        int     k, sh;
        real    th;
        longint c, s;
        for (int b = 0; b < BINCOUNT; b++) begin
            k  = m_ph[b] >> 6;
            th = 2.0 * PI * real'(k) / 1024.0;
            c  = rnd(32767.0 * $cos(th));
            s  = rnd(32767.0 * $sin(th));
            sh = 11 + (OC - 1 - b / BPO);
            m_re[b]  = sat(m_re[b] - (m_re[b] >>> sh) + ((longint'(smp) * c) >>> 15));
            m_im[b]  = sat(m_im[b] - (m_im[b] >>> sh) + ((longint'(smp) * s) >>> 15));
            m_ph[b]  = (m_ph[b] + m_inc[b]) & 32'hFFFF;
            m_out[b] = 36'(absl(m_re[b]) + absl(m_im[b]));
            sb.push_back('{b, sc + b + 3, m_out[b]});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cycle < t) @(negedge clk);
    endtask

    task automatic wait_done();
        wait_until(last_acc + BINCOUNT + 3);
    endtask

    // Drives a one-cycle strobe; the model only takes it if the DUT should be back in IDLE.
    task automatic strobe(input int smp);
        int sc;
        @(negedge clk);
        sc          = cycle + 1;
        inputSample = 16'(smp);
        readSample  = 1'b1;
        if (sc >= last_acc + BINCOUNT + 4) begin
            last_acc   = sc;
            strobe_cyc = sc;
            model_step(smp, sc);
        end
        @(negedge clk);
        readSample = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        int cnt;
        cnt = 0;
        for (int b = 0; b < BINCOUNT; b++) if (outBins[b] !== 36'd0) cnt++;
        check(name, cnt, 0);
    endtask

    task automatic check_all_model(input string name);
        int cnt;
        cnt = 0;
        for (int b = 0; b < BINCOUNT; b++) if (outBins[b] !== m_out[b]) cnt++;
        check(name, cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset_clears_bins");
        model_clear();
        idle(2);
        rst = 1'b1;
    endtask

    function automatic int peak_bin();
        int pk;
        pk = 0;
        for (int b = 1; b < BINCOUNT; b++) if (outBins[b] > outBins[pk]) pk = b;
        return pk;
    endfunction

    function automatic int tone4(input int k);
        case (k % 4)
            1:       return 16000;
            3:       return -16000;
            default: return 0;
        endcase
    endfunction

    initial begin
        longint q [$];
        int     sc;
        real    f60;
        rst = 1'b0; readSample = 1'b0; inputSample = '0;

        // Bin 119 walks phase 0, 1/4, 1/2, 3/4 turn; hand-derived accumulator results.
        vecs[0] = '{16384,  36'd16383};
        vecs[1] = '{16384,  36'd32759};
        vecs[2] = '{-16384, 36'd49128};
        vecs[3] = '{-32768, 36'd81873};
        vecs[4] = '{-16384, 36'd65451};
        vecs[5] = '{16384,  36'd81804};

        for (int b = 0; b < BINCOUNT; b++)
            m_inc[b] = int'(rnd(16384.0 * (2.0 ** (real'(b - (BINCOUNT - 1)) / real'(BPO)))));
        model_clear();

        idle(3);
        check_all_zero("reset_state");
        rst = 1'b1;
        idle(1000);
        check_all_zero("idle_1000");

        for (int k = 0; k < 30; k++) begin
            strobe(0);
            idle(122);
        end
        wait_done();
        check_all_zero("zero_input_stays_zero");

        do_reset();
        for (int i = 0; i < 6; i++) begin
            strobe(vecs[i].sample);
            sc = strobe_cyc;
            if (i == 0) begin
                wait_until(sc + 8);
                strobe(-5000);
            end
            wait_until(sc + 121);
            check($sformatf("bin119_hold_before_write_v%0d", i), outBins[119],
                  (i == 0) ? 36'd0 : vecs[i-1].exp119);
            wait_until(sc + 122);
            check($sformatf("bin119_vec%0d", i), outBins[119], vecs[i].exp119);
            if (i == 0) check_all_model("single_strobe_ignores_second");
        end

        strobe(1234);
        sc = strobe_cyc;
        wait_until(sc + 49);
        do_reset();
        strobe(16384);
        sc = strobe_cyc;
        wait_until(sc + 122);
        check("post_reset_bin119", outBins[119], 36'd16383);
        check_all_model("post_reset_sweep");

        do_reset();
        for (int k = 0; k < 200; k++) begin
            strobe(tone4(k));
            idle(122);
        end
        wait_done();
        check_all_model("fs4_tone_model");
        check("fs4_peak_bin", peak_bin(), 119);
        q.delete();
        for (int b = 0; b < 96; b++) q.push_back(longint'(outBins[b]));
        q.sort();
        check("fs4_peak_vs_median_20x", longint'(outBins[119]) >= 20 * q[48], 1);

        do_reset();
        f60 = real'(m_inc[60]) / 65536.0;
        for (int k = 0; k < 200; k++) begin
            strobe(int'(rnd(16000.0 * $sin(2.0 * PI * f60 * real'(k)))));
            idle(122);
        end
        wait_done();
        check_all_model("bin60_tone_model");
        check("bin60_peak_within_1", (peak_bin() >= 59) && (peak_bin() <= 61), 1);

        wait_done();
        idle(2);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
